// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer; optional stall counter under PIPE_STALL_CNT_EN.
// Latency: in_data appears on out_data 1 cycle after Accept; throughput 1/cycle while out_ready stays high.
// Backpressure: in_ready is ~skid_v_q, a register output, so there is no combinational path from out_ready to in_ready.
module pipe_stage_skid #(
    parameter int WIDTH    = 16,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [1:0]       occ
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
        $error("pipe_stage_skid: WIDTH and CNT_W must be >= 1");
    end

    // State is the {skid_v, main_v} pair; 2'b10 cannot occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic [1:0]       state;
    logic             accept;
    logic             drain;

    assign state     = {skid_v_q, main_v_q};
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign occ       = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign accept    = in_valid & ~skid_v_q;
    assign drain     = main_v_q & out_ready;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (CLR_DATA != 0) begin
                main_d_d = '0;
                skid_d_d = '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_v_d = 1'b1;
                        main_d_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d_d = in_data;
                    end else if (drain) begin
                        main_v_d = 1'b0;
                    end else if (accept) begin
                        skid_v_d = 1'b1;
                        skid_d_d = in_data;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_d_d = skid_d_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= '0;
            skid_d_q <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating; only reset clears it, flush deliberately does not.
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid (WIDTH=16, CLR_DATA=1).
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  occ;
`ifdef PIPE_STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH   (16),
        .CLR_DATA(1),
`ifdef PIPE_STALL_CNT_EN
        .CNT_W   (4)
`else
        .CNT_W   (16)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .occ      (occ)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_occ got %0d want 0", occ); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0000", out_data); end
        // Fill two entries, then reset asynchronously in the middle of a cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h5A5A; step();
        in_data = 16'h6B6B; step();
        in_valid = 1'b0;
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL pre_rst_occ got %0d want 2", occ); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL arst_occ got %0d want 0", occ); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL arst_out_data got %h want 0000", out_data); end
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(i)) begin n_err++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 16'(i)); end
            n_cmp++; if (occ !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%b want occ=1 rdy=1", i, occ, in_ready); end
        end
        in_valid = 1'b0;
        in_data  = 16'hxxxx;
        step();
        n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got occ=%0d v=%b want occ=0 v=0", occ, out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; step();
        n_cmp++; if (occ !== 2'd1 || out_data !== 16'hAAAA) begin n_err++; $display("FAIL bp_first got occ=%0d d=%h want occ=1 d=aaaa", occ, out_data); end
        in_data = 16'hBBBB; step();
        n_cmp++; if (occ !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occ, in_ready); end
        in_data = 16'hCCCC;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (occ !== 2'd2 || out_data !== 16'hAAAA || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got occ=%0d v=%b d=%h want occ=2 v=1 d=aaaa", k, occ, out_valid, out_data); end
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_data !== 16'hBBBB || occ !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rel1 got d=%h occ=%0d rdy=%b want d=bbbb occ=1 rdy=1", out_data, occ, in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 16'hCCCC || occ !== 2'd1) begin n_err++; $display("FAIL bp_rel2 got d=%h occ=%0d want d=cccc occ=1", out_data, occ); end
        step();
        n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got occ=%0d v=%b want occ=0 v=0", occ, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; step();
        in_data = 16'h2222; step();
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL fl_pre_occ got %0d want 2", occ); end
        flush = 1'b1; in_data = 16'h1234; step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL fl_state got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occ, out_valid, in_ready); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL fl_data got %h want 0000", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_leak[%0d] got v=%b d=%h want v=0", k, out_valid, out_data); end
        end
    endtask

    task automatic test_random();
        logic [15:0] mq[$];
        logic        iv, ordy, fl, m_acc, m_drn;
        logic [15:0] d;
        for (int c = 0; c < 10000; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            d    = 16'($urandom);
            in_valid  = iv;
            in_data   = iv ? d : 16'hxxxx;
            out_ready = ordy;
            flush     = fl;
            m_acc = iv && (mq.size() < 2);
            m_drn = (mq.size() > 0) && ordy;
            step();
            if (fl) mq.delete();
            else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) mq.push_back(d);
            end
            n_cmp++; if (occ !== 2'(mq.size()) || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                n_err++; $display("FAIL rnd_ctrl[%0d] got occ=%0d v=%b rdy=%b want occ=%0d", c, occ, out_valid, in_ready, mq.size());
            end
            if (mq.size() > 0) begin
                n_cmp++; if (out_data !== mq[0]) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", c, out_data, mq[0]); end
            end
        end
        in_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL sc_start got %0d want 0", stall_cnt); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0F0F; step();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sc_sat got %0d want 15", stall_cnt); end
        flush = 1'b1; step();
        flush = 1'b0; step();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sc_flush got %0d want 15", stall_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL sc_reset got %0d want 0", stall_cnt); end
        step();
        #2 rst_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifdef PIPE_STALL_CNT_EN
        // Counter must start at zero here, so run before other traffic.
        test_stall_cnt();
`endif
        test_stream();
        test_back_pressure();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
